// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a little-endian byte stream into 32-bit
// words, writes them to instruction memory and holds the CPU in reset until done.
module imem_loader #(
    parameter int ADDR_W    = 8,
    parameter int NUM_WORDS = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [7:0]        byte_i,
    input  logic              byte_valid_i,
    output logic              byte_ready_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_data_o,
    output logic              cpu_rst_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [31:0]       sum_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WORDS - 1);

    state_t            state;
    state_t            state_next;
    logic [1:0]        byte_cnt;
    logic [ADDR_W-1:0] word_idx;
    logic [23:0]       partial;
    logic              accept;
    logic              word_done;
    logic              last_word;
    logic [31:0]       word;

    // Abort wins over a byte offered in the same cycle.
    assign accept    = byte_ready_o && byte_valid_i && !abort_i;
    assign word_done = accept && (byte_cnt == 2'd3);
    assign last_word = (word_idx == LAST_IDX);
    assign word      = {byte_i, partial};

    assign byte_ready_o = (state == S_LOAD);
    assign busy_o       = (state == S_LOAD) || (state == S_FLUSH);
    assign done_o       = (state == S_DONE);
    assign cpu_rst_o    = (state != S_DONE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start_i) state_next = S_LOAD;
            S_LOAD: begin
                if (abort_i)                      state_next = S_IDLE;
                else if (word_done && last_word)  state_next = S_FLUSH;
            end
            S_FLUSH: state_next = S_DONE;
            S_DONE:  if (start_i) state_next = S_LOAD;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            byte_cnt   <= 2'd0;
            word_idx   <= '0;
            partial    <= 24'd0;
            mem_we_o   <= 1'b0;
            mem_addr_o <= '0;
            mem_data_o <= 32'd0;
            sum_o      <= 32'd0;
        end else begin
            mem_we_o <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        byte_cnt <= 2'd0;
                        word_idx <= '0;
                        sum_o    <= 32'd0;
                    end
                end
                S_LOAD: begin
                    if (abort_i) begin
                        byte_cnt <= 2'd0;
                    end else if (accept) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0:    partial[7:0]   <= byte_i;
                            2'd1:    partial[15:8]  <= byte_i;
                            2'd2:    partial[23:16] <= byte_i;
                            default: ;
                        endcase
                        if (word_done) begin
                            mem_we_o   <= 1'b1;
                            mem_addr_o <= word_idx;
                            mem_data_o <= word;
                            sum_o      <= sum_o + word;
                            // Index stops at the last word so the address never wraps.
                            if (!last_word) word_idx <= word_idx + ADDR_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader with a two-word image.
module tb_imem_loader;

    localparam int ADDR_W    = 8;
    localparam int NUM_WORDS = 2;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              start_i = 1'b0;
    logic              abort_i = 1'b0;
    logic [7:0]        byte_i = 8'h00;
    logic              byte_valid_i = 1'b0;
    logic              byte_ready_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_data_o;
    logic              cpu_rst_o;
    logic              busy_o;
    logic              done_o;
    logic [31:0]       sum_o;

    int passed = 0;
    int total  = 0;
    int timeouts = 0;
    int acc_cnt = 0;
    logic [ADDR_W-1:0] wa_q[$];
    logic [31:0]       wd_q[$];

    imem_loader #(.ADDR_W(ADDR_W), .NUM_WORDS(NUM_WORDS)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
        .byte_i(byte_i), .byte_valid_i(byte_valid_i), .byte_ready_o(byte_ready_o),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .cpu_rst_o(cpu_rst_o), .busy_o(busy_o), .done_o(done_o), .sum_o(sum_o)
    );

    always #5 clk_i = ~clk_i;

    // Observe once per cycle, well away from either edge.
    always begin
        @(negedge clk_i);
        #2;
        if (mem_we_o) begin
            wa_q.push_back(mem_addr_o);
            wd_q.push_back(mem_data_o);
        end
        if (byte_valid_i && byte_ready_o && !abort_i && !rst_i) acc_cnt++;
    end

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        acc_cnt = 0;
    endtask

    task automatic do_start();
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        byte_i = b;
        byte_valid_i = 1'b1;
        while (!byte_ready_o && t < 20) begin
            @(negedge clk_i);
            t++;
        end
        if (!byte_ready_o) timeouts++;
        else @(negedge clk_i);
        byte_valid_i = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        for (int i = 0; i < 4; i++) begin
            if (gap) begin
                byte_i = 8'hAA;
                byte_valid_i = 1'b0;
                @(negedge clk_i);
            end
            send_byte(w[8*i +: 8]);
        end
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!done_o && t < 20) begin
            @(negedge clk_i);
            t++;
        end
        if (!done_o) timeouts++;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        total++; if (mem_we_o !== 1'b0) $display("FAIL reset_we got=%0h exp=0", mem_we_o); else passed++;
        total++; if (mem_addr_o !== 8'h00) $display("FAIL reset_addr got=%0h exp=0", mem_addr_o); else passed++;
        total++; if (mem_data_o !== 32'h0) $display("FAIL reset_data got=%0h exp=0", mem_data_o); else passed++;
        total++; if (sum_o !== 32'h0) $display("FAIL reset_sum got=%0h exp=0", sum_o); else passed++;
        total++; if ({busy_o, done_o, cpu_rst_o, byte_ready_o} !== 4'b0010)
            $display("FAIL reset_ctl got=%b exp=0010", {busy_o, done_o, cpu_rst_o, byte_ready_o}); else passed++;
        rst_i = 1'b0;
        @(negedge clk_i);
        total++; if (byte_ready_o !== 1'b0) $display("FAIL idle_ready got=%0h exp=0", byte_ready_o); else passed++;
    endtask

    task automatic test_load();
        clear_log();
        do_start();
        total++; if ({busy_o, byte_ready_o, cpu_rst_o} !== 3'b111)
            $display("FAIL load_enter got=%b exp=111", {busy_o, byte_ready_o, cpu_rst_o}); else passed++;
        send_word(32'h00100013, 1'b0);
        send_word(32'h002080B3, 1'b0);
        // In FLUSH: bytes offered must be refused.
        byte_i = 8'h77;
        byte_valid_i = 1'b1;
        total++; if ({busy_o, mem_we_o, byte_ready_o, done_o} !== 4'b1100)
            $display("FAIL flush_ctl got=%b exp=1100", {busy_o, mem_we_o, byte_ready_o, done_o}); else passed++;
        total++; if (mem_addr_o !== 8'h01 || mem_data_o !== 32'h002080B3)
            $display("FAIL flush_word got=%0h:%0h exp=1:2080b3", mem_addr_o, mem_data_o); else passed++;
        @(negedge clk_i);
        total++; if ({done_o, cpu_rst_o, busy_o, mem_we_o, byte_ready_o} !== 5'b10000)
            $display("FAIL done_ctl got=%b exp=10000", {done_o, cpu_rst_o, busy_o, mem_we_o, byte_ready_o}); else passed++;
        total++; if (sum_o !== 32'h003080C6) $display("FAIL load_sum got=%0h exp=3080c6", sum_o); else passed++;
        repeat (3) @(negedge clk_i);
        byte_valid_i = 1'b0;
        total++; if (done_o !== 1'b1 || mem_addr_o !== 8'h01 || mem_data_o !== 32'h002080B3)
            $display("FAIL done_hold got=%0h %0h:%0h exp=1 1:2080b3", done_o, mem_addr_o, mem_data_o); else passed++;
        total++; if (wa_q.size() != 2) $display("FAIL load_nwrites got=%0d exp=2", wa_q.size());
        else if (wa_q[0] !== 8'h00 || wd_q[0] !== 32'h00100013 || wa_q[1] !== 8'h01 || wd_q[1] !== 32'h002080B3)
            $display("FAIL load_writes got=%0h:%0h %0h:%0h exp=0:100013 1:2080b3", wa_q[0], wd_q[0], wa_q[1], wd_q[1]);
        else passed++;
        total++; if (acc_cnt != 8) $display("FAIL load_accepts got=%0d exp=8", acc_cnt); else passed++;
    endtask

    task automatic test_toggle_valid();
        clear_log();
        do_start();
        total++; if (cpu_rst_o !== 1'b1) $display("FAIL restart_cpu_rst got=%0h exp=1", cpu_rst_o); else passed++;
        send_word(32'h00100013, 1'b1);
        send_word(32'h002080B3, 1'b1);
        byte_valid_i = 1'b1;
        wait_done();
        repeat (2) @(negedge clk_i);
        byte_valid_i = 1'b0;
        total++; if (sum_o !== 32'h003080C6 || done_o !== 1'b1)
            $display("FAIL toggle_end got=%0h done=%0h exp=3080c6 done=1", sum_o, done_o); else passed++;
        total++; if (wa_q.size() != 2) $display("FAIL toggle_nwrites got=%0d exp=2", wa_q.size());
        else if (wa_q[0] !== 8'h00 || wd_q[0] !== 32'h00100013 || wa_q[1] !== 8'h01 || wd_q[1] !== 32'h002080B3)
            $display("FAIL toggle_writes got=%0h:%0h %0h:%0h exp=0:100013 1:2080b3", wa_q[0], wd_q[0], wa_q[1], wd_q[1]);
        else passed++;
        total++; if (acc_cnt != 8) $display("FAIL toggle_accepts got=%0d exp=8", acc_cnt); else passed++;
    endtask

    task automatic test_abort();
        clear_log();
        do_start();
        send_word(32'h00100013, 1'b0);
        send_byte(8'hB3);
        send_byte(8'h80);
        abort_i = 1'b1;
        byte_i = 8'h55;
        byte_valid_i = 1'b1;
        @(negedge clk_i);
        abort_i = 1'b0;
        byte_valid_i = 1'b0;
        total++; if ({busy_o, done_o, cpu_rst_o, byte_ready_o} !== 4'b0010)
            $display("FAIL abort_ctl got=%b exp=0010", {busy_o, done_o, cpu_rst_o, byte_ready_o}); else passed++;
        total++; if (sum_o !== 32'h00100013) $display("FAIL abort_sum got=%0h exp=100013", sum_o); else passed++;
        repeat (3) @(negedge clk_i);
        total++; if (wa_q.size() != 1) $display("FAIL abort_nwrites got=%0d exp=1", wa_q.size());
        else if (wa_q[0] !== 8'h00 || wd_q[0] !== 32'h00100013)
            $display("FAIL abort_write got=%0h:%0h exp=0:100013", wa_q[0], wd_q[0]);
        else passed++;
        clear_log();
        do_start();
        send_word(32'h00100013, 1'b0);
        send_word(32'h002080B3, 1'b0);
        wait_done();
        @(negedge clk_i);
        total++; if (sum_o !== 32'h003080C6 || cpu_rst_o !== 1'b0)
            $display("FAIL reload_end got=%0h cpu_rst=%0h exp=3080c6 cpu_rst=0", sum_o, cpu_rst_o); else passed++;
        total++; if (wa_q.size() != 2) $display("FAIL reload_nwrites got=%0d exp=2", wa_q.size());
        else if (wa_q[0] !== 8'h00 || wd_q[0] !== 32'h00100013 || wa_q[1] !== 8'h01 || wd_q[1] !== 32'h002080B3)
            $display("FAIL reload_writes got=%0h:%0h %0h:%0h exp=0:100013 1:2080b3", wa_q[0], wd_q[0], wa_q[1], wd_q[1]);
        else passed++;
    endtask

    task automatic test_reset_mid_word();
        clear_log();
        do_start();
        send_word(32'h00100013, 1'b0);
        send_byte(8'hB3);
        send_byte(8'h80);
        send_byte(8'h20);
        rst_i = 1'b1;
        start_i = 1'b1;
        byte_i = 8'h00;
        byte_valid_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        start_i = 1'b0;
        byte_valid_i = 1'b0;
        total++; if ({mem_we_o, busy_o, done_o, cpu_rst_o, byte_ready_o} !== 5'b00010)
            $display("FAIL midrst_ctl got=%b exp=00010", {mem_we_o, busy_o, done_o, cpu_rst_o, byte_ready_o}); else passed++;
        total++; if (mem_addr_o !== 8'h00 || mem_data_o !== 32'h0 || sum_o !== 32'h0)
            $display("FAIL midrst_regs got=%0h:%0h sum=%0h exp=0:0 sum=0", mem_addr_o, mem_data_o, sum_o); else passed++;
        repeat (4) @(negedge clk_i);
        total++; if (wa_q.size() != 1) $display("FAIL midrst_nwrites got=%0d exp=1", wa_q.size()); else passed++;
    endtask

    task automatic test_reload_wrap();
        do_start();
        send_word(32'h00100013, 1'b0);
        send_word(32'h002080B3, 1'b0);
        wait_done();
        clear_log();
        do_start();
        total++; if (cpu_rst_o !== 1'b1 || done_o !== 1'b0)
            $display("FAIL wrap_start got=cpu_rst %0h done %0h exp=1 0", cpu_rst_o, done_o); else passed++;
        total++; if (sum_o !== 32'h0) $display("FAIL wrap_clear got=%0h exp=0", sum_o); else passed++;
        send_word(32'hFFFFFFFF, 1'b0);
        total++; if (cpu_rst_o !== 1'b1) $display("FAIL wrap_midload got=%0h exp=1", cpu_rst_o); else passed++;
        send_word(32'h00000001, 1'b0);
        wait_done();
        @(negedge clk_i);
        total++; if (sum_o !== 32'h0 || done_o !== 1'b1)
            $display("FAIL wrap_end got=%0h done=%0h exp=0 done=1", sum_o, done_o); else passed++;
        total++; if (wa_q.size() != 2) $display("FAIL wrap_nwrites got=%0d exp=2", wa_q.size());
        else if (wa_q[0] !== 8'h00 || wd_q[0] !== 32'hFFFFFFFF || wa_q[1] !== 8'h01 || wd_q[1] !== 32'h00000001)
            $display("FAIL wrap_writes got=%0h:%0h %0h:%0h exp=0:ffffffff 1:1", wa_q[0], wd_q[0], wa_q[1], wd_q[1]);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_load();
        test_toggle_valid();
        test_abort();
        test_reset_mid_word();
        test_reload_wrap();
        total++; if (timeouts != 0) $display("FAIL handshake_timeouts got=%0d exp=0", timeouts); else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_W, default 8, width of instruction-memory word address.
REQ-002 Parameter NUM_WORDS, default 64, words per image; legal range 1..2^ADDR_W.
REQ-003 clk_i  in  1  single clock; all state changes on rising edge.
REQ-004 rst_i  in  1  synchronous, active-high reset.
REQ-005 start_i  in  1  begin image load (level sampled each cycle).
REQ-006 abort_i  in  1  cancel load in progress.
REQ-007 byte_i  in  8  incoming image byte.
REQ-008 byte_valid_i  in  1  byte_i valid.
REQ-009 byte_ready_o  out  1  loader accepts byte this cycle.
REQ-010 mem_we_o  out  1  instruction-memory write strobe.
REQ-011 mem_addr_o  out  ADDR_W  instruction-memory word address.
REQ-012 mem_data_o  out  32  instruction-memory write word.
REQ-013 cpu_rst_o  out  1  holds downstream DataPath in reset while high.
REQ-014 busy_o  out  1  high in LOAD or FLUSH.
REQ-015 done_o  out  1  high in DONE.
REQ-016 sum_o  out  32  running checksum of written words.

Function
REQ-017 States: IDLE, LOAD, FLUSH, DONE; encoding free.
REQ-018 Byte handshake: transfer occurs only when byte_valid_i && byte_ready_o on a rising edge; byte_i ignored otherwise.
REQ-019 byte_ready_o = 1 only in LOAD; 0 in IDLE, FLUSH, DONE (combinational from state).
REQ-020 IDLE: start_i=1 -> LOAD next cycle; byte counter, word index, sum_o cleared to 0 on that edge.
REQ-021 Word assembly little-endian: 1st accepted byte -> bits 7:0, 2nd -> 15:8, 3rd -> 23:16, 4th -> 31:24.
REQ-022 On edge accepting a 4th byte: mem_data_o <= assembled word, mem_addr_o <= word index, mem_we_o = 1 for exactly the following cycle; word index increments; sum_o <= sum_o + word (modulo 2^32) on same edge.
REQ-023 LOAD continues accepting bytes of the next word during a write cycle; mem_data_o/mem_addr_o held stable while mem_we_o=1.
REQ-024 Edge accepting the final byte (byte 4*NUM_WORDS) -> FLUSH; FLUSH lasts one cycle with mem_we_o=1 for last word, then -> DONE.
REQ-025 mem_we_o = 0 in all cycles other than those of REQ-022/REQ-024.
REQ-026 cpu_rst_o = 1 in IDLE, LOAD, FLUSH; 0 in DONE.
REQ-027 DONE: done_o=1; holds until rst_i or start_i; start_i=1 -> LOAD with counters/sum cleared, cpu_rst_o=1 from next cycle.
REQ-028 start_i in LOAD or FLUSH ignored.
REQ-029 abort_i=1 in LOAD -> IDLE next cycle; partial word discarded, no write issued for it; sum_o retains value of completed words; abort_i has priority over a simultaneous byte transfer (byte not accepted counted). abort_i ignored in IDLE, FLUSH, DONE.
REQ-030 Word index wraps never: load terminates at NUM_WORDS, so mem_addr_o max = NUM_WORDS-1.
REQ-031 mem_addr_o, mem_data_o, sum_o hold last value in IDLE/DONE.

Reset
REQ-032 rst_i=1 at any edge, any state (including mid-word, mid-FLUSH): state <= IDLE, byte counter and word index <= 0, mem_we_o=0, mem_addr_o=0, mem_data_o=0, sum_o=0, busy_o=0, done_o=0, cpu_rst_o=1, byte_ready_o=0; rst_i overrides start_i/abort_i.

Verification
REQ-033 NUM_WORDS=2; start; bytes 0x13,0x00,0x10,0x00 then 0xB3,0x80,0x20,0x00, valid continuous -> write addr0 data 0x00100013, write addr1 data 0x002080B3 (FLUSH), done_o=1, cpu_rst_o=0, sum_o=0x003080C6.
REQ-034 Same image with byte_valid_i toggling every other cycle -> identical writes/sum; no byte accepted when valid=0; no byte accepted in FLUSH/DONE even if valid=1.
REQ-035 Abort after 6 bytes -> exactly one write (addr0), IDLE next cycle, sum_o=0x00100013, cpu_rst_o=1; restart then full image -> addr0 rewritten, REQ-033 results.
REQ-036 rst_i asserted after 3 bytes of word 1 -> all outputs at REQ-032 values next cycle, no spurious mem_we_o.
REQ-037 From DONE, start_i=1 with new image 0xFFFFFFFF,0x00000001 -> cpu_rst_o=1 during reload, writes at addr0/1, sum_o=0x00000000 (wrap), done_o=1 at end.
